// File: rtl/wreg_pkg.sv
// Shared definitions for the W-register writeback unit: write-source classes,
// Q-phase encodings and the width of the context-stack occupancy count.
package wreg_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        CLRW  = 3'd1,
        ALU_D = 3'd2,
        GPR_D = 3'd3,
        LIT   = 3'd4,
        ALU_W = 3'd5
    } wr_class_e;

    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;

    localparam int CNT_W = 4;

endpackage

// File: rtl/wreg_ctx_stack.sv
// LIFO context stack for W. Push, pop and swap arrive already qualified to the Q4
// edge; misuse (push when full, pop/swap when empty) is dropped and sets a sticky flag.
module wreg_ctx_stack
    import wreg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CTX_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_swap,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_top,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_err
);

    localparam int IDX_W = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [CTX_DEPTH];
    logic [CNT_W-1:0]      r_count;
    logic                  r_err;
    logic                  w_full;
    logic                  w_empty;
    logic [IDX_W-1:0]      w_top_idx;
    logic [IDX_W-1:0]      w_push_idx;

    assign w_full     = (r_count == CNT_W'(CTX_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_top_idx  = IDX_W'(r_count - CNT_W'(1));
    assign w_push_idx = IDX_W'(r_count);

    // NOTE: the storage array has no reset; the count decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (i_push && !w_full)
                r_mem[w_push_idx] <= i_data;
            else if (i_swap && !w_empty)
                r_mem[w_top_idx] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (i_push) begin
                if (w_full) r_err   <= 1'b1;
                else        r_count <= r_count + CNT_W'(1);
            end
            if (i_pop) begin
                if (w_empty) r_err   <= 1'b1;
                else         r_count <= r_count - CNT_W'(1);
            end
            // A swap on an empty stack behaves as an empty pop.
            if (i_swap && w_empty)
                r_err <= 1'b1;
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: rtl/wreg_writeback_unit.sv
// W-register writeback with a free-running Q1..Q4 phase counter; W and the context
// stack change only on the edge that ends Q4. Define WREG_CTX_STACK_EN to build the stack in.
module wreg_writeback_unit
    import wreg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CTX_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic [2:0]            wr_class,
    input  logic                  dest_f,
    input  logic [DATA_WIDTH-1:0] literal,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] gpr_in,
    input  logic                  ctx_save,
    input  logic                  ctx_restore,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic [1:0]            q_phase,
    output logic [3:0]            ctx_count,
    output logic                  ctx_full,
    output logic                  ctx_empty,
    output logic                  ctx_err
);

    logic [1:0]            r_q;
    logic [DATA_WIDTH-1:0] r_w;
    logic [DATA_WIDTH-1:0] w_class_w;
    logic [DATA_WIDTH-1:0] w_w_next;
    logic                  w_q4_edge;

    assign w_q4_edge = (r_q == Q4) && !stall;

    // NOTE: defaulting to the held value first keeps this block free of latches.
    always_comb begin
        w_class_w = r_w;
        case (wr_class_e'(wr_class))
            CLRW:    w_class_w = '0;
            ALU_D:   if (!dest_f) w_class_w = alu_result;
            GPR_D:   if (!dest_f) w_class_w = gpr_in;
            LIT:     w_class_w = literal;
            ALU_W:   w_class_w = alu_result;
            default: w_class_w = r_w;
        endcase
    end

`ifdef WREG_CTX_STACK_EN
    logic [DATA_WIDTH-1:0] w_top;
    logic [3:0]            w_count;
    logic                  w_err;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_swap;

    assign w_push = w_q4_edge &&  ctx_save && !ctx_restore;
    assign w_pop  = w_q4_edge && !ctx_save &&  ctx_restore;
    assign w_swap = w_q4_edge &&  ctx_save &&  ctx_restore;

    // The pushed/swapped value is W before this edge's update.
    wreg_ctx_stack #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTX_DEPTH  (CTX_DEPTH)
    ) u_ctx_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_swap  (w_swap),
        .i_data  (r_w),
        .o_top   (w_top),
        .o_count (w_count),
        .o_err   (w_err)
    );

    // A successful restore (alone or as a swap) overrides the class write.
    assign w_w_next  = (ctx_restore && (w_count != 4'd0)) ? w_top : w_class_w;
    assign ctx_count = w_count;
    assign ctx_err   = w_err;
`else
    logic w_unused_ctx;

    assign w_unused_ctx = ctx_save ^ ctx_restore;
    assign w_w_next     = w_class_w;
    assign ctx_count    = 4'd0;
    assign ctx_err      = 1'b0;
`endif

    assign ctx_full  = (ctx_count == 4'(CTX_DEPTH));
    assign ctx_empty = (ctx_count == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= Q1;
            r_w <= '0;
        end else if (!stall) begin
            r_q <= r_q + 2'd1;
            if (w_q4_edge)
                r_w <= w_w_next;
        end
    end

    assign w_out   = r_w;
    assign q_phase = r_q;

endmodule
